// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared types and constants for the animation frame sequencer.
//   state_t       - sequencer FSM state encoding (IDLE / ARM / WAIT)
//   MODE_*        - encodings of the 2-bit sequence mode input
package frame_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [1:0] MODE_LOOP     = 2'b00;
   localparam logic [1:0] MODE_ONESHOT  = 2'b01;
   localparam logic [1:0] MODE_PINGPONG = 2'b10;

endpackage

// File: rtl/frame_step.sv
// frame_step: combinational next-frame logic for frame_seq.
//   frame     in  current frame index
//   mode      in  captured sequence mode
//   dir       in  current direction, 1 = counting down (FRAME_SEQ_PINGPONG_EN only)
//   dir_nxt   out direction after this step (FRAME_SEQ_PINGPONG_EN only)
//   frame_nxt out frame index after this step
//   seq_end   out one-shot sequence is complete; frame must hold
// Optional feature macro: FRAME_SEQ_PINGPONG_EN (enables ping-pong mode).
module frame_step
   import frame_seq_pkg::*;
#(
   parameter int FRAMES = 8,
   localparam int W = $clog2(FRAMES)
) (
   input  logic [W-1:0] frame,
   input  logic [1:0]   mode,
`ifdef FRAME_SEQ_PINGPONG_EN
   input  logic         dir,
   output logic         dir_nxt,
`endif
   output logic [W-1:0] frame_nxt,
   output logic         seq_end
);

   localparam logic [W-1:0] LAST = W'(FRAMES - 1);
   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] ZERO = '0;

   always_comb begin
      frame_nxt = frame + ONE;
      seq_end   = 1'b0;
`ifdef FRAME_SEQ_PINGPONG_EN
      dir_nxt   = dir;
`endif
      if (frame == LAST) begin
         if (mode == MODE_ONESHOT) begin
            frame_nxt = frame;
            seq_end   = 1'b1;
         end
`ifdef FRAME_SEQ_PINGPONG_EN
         else if (mode == MODE_PINGPONG) begin
            // turn around without revisiting the top frame
            frame_nxt = frame - ONE;
            dir_nxt   = 1'b1;
         end
`endif
         else begin
            frame_nxt = ZERO;
         end
      end
`ifdef FRAME_SEQ_PINGPONG_EN
      // downward leg; dir is only ever set while in ping-pong mode
      if (mode == MODE_PINGPONG && dir) begin
         if (frame == ZERO) begin
            frame_nxt = ONE;
            dir_nxt   = 1'b0;
         end else begin
            frame_nxt = frame - ONE;
         end
      end
`endif
   end

endmodule

// File: rtl/frame_seq.sv
// frame_seq: animation frame sequencer driven by a one-shot tick timer.
//   clk       in  clock, rising edge
//   rst       in  synchronous active-high reset
//   start     in  launch a sequence from IDLE
//   stop      in  abort a running sequence
//   mode      in  00 loop, 01 one-shot, 10 ping-pong, 11 loop; captured at start
//   tick      in  single-cycle pulse from the tick timer
//   tmr_trig  out one-cycle pulse re-arming the tick timer (ARM decode)
//   frame     out current frame index
//   frame_stb out pulse the cycle after frame advances on a tick
//   busy      out high in ARM or WAIT
//   done      out pulse when a one-shot sequence completes
// Optional feature macro: FRAME_SEQ_PINGPONG_EN (mode 10 runs ping-pong;
// otherwise mode 10 behaves as loop and no direction register exists).
//
// state | meaning
// IDLE  | sequencer stopped, frame holds its last value
// ARM   | pulse tmr_trig for one cycle to start the tick timer
// WAIT  | wait for the timer tick, then step the frame
module frame_seq
   import frame_seq_pkg::*;
#(
   parameter int FRAMES = 8,
   localparam int W = $clog2(FRAMES)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic [1:0]   mode,
   input  logic         tick,
   output logic         tmr_trig,
   output logic [W-1:0] frame,
   output logic         frame_stb,
   output logic         busy,
   output logic         done
);

   state_t       state_q, state_d;
   logic [W-1:0] frame_q, frame_d;
   logic [1:0]   mode_q, mode_d;
   logic         frame_stb_q, frame_stb_d;
   logic         done_q, done_d;
   logic [W-1:0] frame_nxt;
   logic         seq_end;
`ifdef FRAME_SEQ_PINGPONG_EN
   logic         dir_q, dir_d;
   logic         dir_nxt;
`endif

   frame_step #(.FRAMES(FRAMES)) u_step (
      .frame     (frame_q),
      .mode      (mode_q),
`ifdef FRAME_SEQ_PINGPONG_EN
      .dir       (dir_q),
      .dir_nxt   (dir_nxt),
`endif
      .frame_nxt (frame_nxt),
      .seq_end   (seq_end)
   );

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      mode_d      = mode_q;
      frame_stb_d = 1'b0;
      done_d      = 1'b0;
`ifdef FRAME_SEQ_PINGPONG_EN
      dir_d       = dir_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = ARM;
               frame_d = '0;
               mode_d  = mode;
`ifdef FRAME_SEQ_PINGPONG_EN
               dir_d   = 1'b0;
`endif
            end
         end
         ARM: begin
            state_d = stop ? IDLE : WAIT;
         end
         WAIT: begin
            // stop takes priority over a coincident tick
            if (stop) begin
               state_d = IDLE;
            end else if (tick) begin
               if (seq_end) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_d     = frame_nxt;
                  frame_stb_d = 1'b1;
                  state_d     = ARM;
`ifdef FRAME_SEQ_PINGPONG_EN
                  dir_d       = dir_nxt;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         frame_q     <= '0;
         mode_q      <= MODE_LOOP;
         frame_stb_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef FRAME_SEQ_PINGPONG_EN
         dir_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         mode_q      <= mode_d;
         frame_stb_q <= frame_stb_d;
         done_q      <= done_d;
`ifdef FRAME_SEQ_PINGPONG_EN
         dir_q       <= dir_d;
`endif
      end
   end

   assign tmr_trig  = (state_q == ARM);
   assign busy      = (state_q != IDLE);
   assign frame     = frame_q;
   assign frame_stb = frame_stb_q;
   assign done      = done_q;

endmodule

// File: tb/tb_frame_seq.sv
// tb_frame_seq: self-checking bench for frame_seq with FRAMES=4.
// Expected frames come from closed-form arithmetic on the tick count.
module tb_frame_seq;

   localparam int F = 4;
   localparam int W = $clog2(F);

   logic         clk = 1'b0;
   logic         rst, start, stop, tick;
   logic [1:0]   mode;
   logic         tmr_trig, frame_stb, busy, done;
   logic [W-1:0] frame;

   int           checks   = 0;
   int           failures = 0;
   int           mdl_n;
   logic [1:0]   mdl_mode;
   bit           ended;

   frame_seq #(.FRAMES(F)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .tick      (tick),
      .tmr_trig  (tmr_trig),
      .frame     (frame),
      .frame_stb (frame_stb),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // frame reached after n ticks of a sequence started in mode m
   function automatic int exp_frame(input logic [1:0] m, input int n);
      int p;
      if (m == 2'b01) return (n >= F - 1) ? F - 1 : n;
`ifdef FRAME_SEQ_PINGPONG_EN
      if (m == 2'b10) begin
         p = n % (2 * F - 2);
         return (p < F) ? p : 2 * F - 2 - p;
      end
`endif
      return n % F;
   endfunction

   task automatic chk_idle(input string tag, input int fr);
      chk({tag, "_frame"}, 32'(frame), fr);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_trig"},  32'(tmr_trig), 0);
      chk({tag, "_stb"},   32'(frame_stb), 0);
      chk({tag, "_done"},  32'(done), 0);
   endtask

   task automatic start_seq(input logic [1:0] m);
      start = 1'b1;
      stop  = 1'b0;
      mode  = m;
      cyc();
      start = 1'b0;
      mode  = 2'($urandom);
      mdl_n    = 0;
      mdl_mode = m;
      ended    = 1'b0;
      chk("arm_trig",  32'(tmr_trig), 1);
      chk("arm_busy",  32'(busy), 1);
      chk("arm_frame", 32'(frame), 0);
      chk("arm_stb",   32'(frame_stb), 0);
      cyc();
      chk("wait_trig", 32'(tmr_trig), 0);
      chk("wait_busy", 32'(busy), 1);
   endtask

   task automatic do_tick(input int gap);
      repeat (gap) begin
         start = 1'($urandom);
         mode  = 2'($urandom);
         cyc();
         chk("gap_trig", 32'(tmr_trig), 0);
         chk("gap_stb",  32'(frame_stb), 0);
         chk("gap_busy", 32'(busy), 1);
      end
      tick = 1'b1;
      cyc();
      tick  = 1'b0;
      start = 1'b0;
      mdl_n++;
      ended = (mdl_mode == 2'b01) && (mdl_n == F);
      chk("tick_frame", 32'(frame), exp_frame(mdl_mode, mdl_n));
      chk("tick_stb",   32'(frame_stb), 32'(!ended));
      chk("tick_done",  32'(done), 32'(ended));
      chk("tick_busy",  32'(busy), 32'(!ended));
      chk("tick_trig",  32'(tmr_trig), 32'(!ended));
      if (!ended) begin
         cyc();
         chk("rearm_trig", 32'(tmr_trig), 0);
      end
   endtask

   task automatic stop_seq();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk_idle("stop", exp_frame(mdl_mode, mdl_n));
   endtask

   initial begin
      int n;
      logic [1:0] m;
      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      tick  = 1'b0;
      mode  = 2'b00;
      repeat (2) cyc();
      chk_idle("reset", 0);
      rst = 1'b0;

      // tick while idle is ignored
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk_idle("idle_tick", 0);

      // loop: 1,2,3,0,1,2
      start_seq(2'b00);
      for (int i = 0; i < 6; i++) do_tick($urandom_range(0, 2));
      chk("loop_final", 32'(frame), 2);
      stop_seq();

      // one-shot: 1,2,3 then done on the 4th tick
      start_seq(2'b01);
      for (int i = 0; i < 4; i++) do_tick($urandom_range(0, 2));
      chk("oneshot_frame", 32'(frame), 3);
      cyc();
      chk_idle("oneshot_after", 3);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk_idle("oneshot_extra_tick", 3);

      // stop coincident with tick at frame 2
      start_seq(2'b00);
      do_tick(0);
      do_tick(1);
      stop = 1'b1;
      tick = 1'b1;
      cyc();
      stop = 1'b0;
      tick = 1'b0;
      chk_idle("stop_tick", 2);
      cyc();
      chk_idle("stop_tick_hold", 2);

      // reset in WAIT at frame 3, then start+stop together in IDLE
      start_seq(2'b00);
      for (int i = 0; i < 3; i++) do_tick(0);
      chk("pre_rst_frame", 32'(frame), 3);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_idle("rst_mid", 0);
      start = 1'b1;
      stop  = 1'b1;
      cyc();
      start = 1'b0;
      stop  = 1'b0;
      chk_idle("start_stop", 0);
      cyc();
      chk_idle("start_stop_hold", 0);

      // mode 10: ping-pong when enabled, loop otherwise
      start_seq(2'b10);
      for (int i = 0; i < 8; i++) do_tick($urandom_range(0, 1));
`ifdef FRAME_SEQ_PINGPONG_EN
      chk("pp_final", 32'(frame), 2);
`else
      chk("pp_final", 32'(frame), 0);
`endif
      stop_seq();

      // reserved mode behaves as loop
      start_seq(2'b11);
      for (int i = 0; i < 5; i++) do_tick(0);
      chk("rsv_final", 32'(frame), 1);
      stop_seq();

      // stop while in ARM
      start = 1'b1;
      mode  = 2'b00;
      cyc();
      start = 1'b0;
      chk("arm_stop_trig", 32'(tmr_trig), 1);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk_idle("arm_stop", 0);

      // randomized runs
      repeat (8) begin
         m = 2'($urandom);
         start_seq(m);
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            if (!ended) do_tick($urandom_range(0, 3));
         end
         if (!ended) stop_seq();
         else begin
            cyc();
            chk_idle("rand_end", F - 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
